// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage with a DEPTH-entry prefetch queue.
//               Sequences the PC, issues req/ack fetches to instruction
//               memory, buffers {pc, word} pairs and presents the head entry
//               to decode over a valid/ready handshake. Redirect flushes the
//               queue and restarts fetch at the new (word-aligned) PC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              pc_plus8,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        word_mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic [31:0]        redir_pc;

  // Next-state, queue bookkeeping and fetch address sequencing
  always_comb begin
    push       = (state_q == S_FETCH) & imem_ack & ~redirect;
    pop        = instr_valid & instr_ready & ~redirect;
    redir_pc   = {redirect_pc[31:2], 2'b00};
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) begin
          fetch_pc_d = redir_pc;
          addr_d     = redir_pc;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
          if (imem_ack) begin
            addr_d = redir_pc;
          end else begin
            // Request in flight: keep its address until the ack retires it
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          addr_d     = addr_q + 32'd4;
          fetch_pc_d = addr_q + 32'd4;
          if (count_d == DEPTH_CNT) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
          addr_d     = redir_pc;
          state_d    = S_FETCH;
        end else if (pop) begin
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end
        if (imem_ack) begin
          // Stale data discarded; reissue from the most recent redirect target
          addr_d  = redirect ? redir_pc : fetch_pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= addr_q;
      word_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Head presentation; data forced to zero while the queue is empty
  always_comb begin
    imem_req    = (state_q == S_FETCH) || (state_q == S_DROP);
    imem_addr   = addr_q;
    q_count     = count_q;
    instr_valid = (count_q != '0);
    instr       = instr_valid ? word_mem_q[rd_ptr_q] : 32'h0;
    instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    pc_plus8    = instr_pc + 32'd8;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A scoreboard holds the
//               PCs of fetches the bench expects to be queued; each decode
//               handshake pops and compares pc, word and pc+8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  q_count;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;
  logic [31:0] head_pc;
  bit          auto_ack;
  bit          drop_next;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus8    (pc_plus8),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One clock: respond to memory, score handshakes, advance to edge+1
  task automatic cycle();
    if (auto_ack) begin
      imem_ack   = imem_req;
      imem_rdata = mem_word(imem_addr);
    end
    if (instr_valid && instr_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", instr_pc, 32'hDEAD_BEEF);
      end else begin
        head_pc = sb_q.pop_front();
        chk("instr_pc", instr_pc, head_pc);
        chk("instr", instr, mem_word(head_pc));
        chk("pc_plus8", pc_plus8, head_pc + 32'd8);
      end
    end
    if (imem_req && imem_ack && !redirect) begin
      if (drop_next) begin
        drop_next = 1'b0;
      end else begin
        chk("imem_addr", imem_addr, exp_pc);
        sb_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (redirect) begin
      sb_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    auto_ack    = 1'b0;
    drop_next   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    sb_q.delete();
    exp_pc = RESET_PC;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b0; auto_ack = 1'b0; drop_next = 1'b0; exp_pc = RESET_PC;
    #3;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_count", {29'h0, q_count}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // 1: streaming, ack same cycle as req, decode always ready
    do_reset();
    instr_ready = 1'b1;
    auto_ack    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i >= 1) chk("t1_no_gap", {31'h0, instr_valid}, 32'h1);
    end

    // 2: decode stalled until queue fills, then one pop
    do_reset();
    auto_ack = 1'b1;
    repeat (8) cycle();
    chk("t2_count_full", {29'h0, q_count}, 32'd4);
    chk("t2_req_full", {31'h0, imem_req}, 32'h0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    chk("t2_count_3", {29'h0, q_count}, 32'd3);
    chk("t2_req_resume", {31'h0, imem_req}, 32'h1);
    chk("t2_addr_resume", imem_addr, 32'h10);
    cycle();
    chk("t2_refill", {29'h0, q_count}, 32'd4);
    instr_ready = 1'b1;
    repeat (8) cycle();

    // 3: redirect while a request waits for a delayed ack
    do_reset();
    instr_ready = 1'b1;
    auto_ack    = 1'b1;
    repeat (3) cycle();
    chk("t3_addr8", imem_addr, 32'h8);
    auto_ack    = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    drop_next   = 1'b1;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t3_addr_hold", imem_addr, 32'h8);
      chk("t3_req_hold", {31'h0, imem_req}, 32'h1);
      chk("t3_flushed", {31'h0, instr_valid}, 32'h0);
      cycle();
    end
    chk("t3_addr_hold", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(32'h8);
    cycle();
    imem_ack = 1'b0;
    chk("t3_addr_new", imem_addr, 32'h100);
    chk("t3_req_new", {31'h0, imem_req}, 32'h1);
    auto_ack = 1'b1;
    cycle();
    chk("t3_first_pc", instr_pc, 32'h100);
    repeat (5) cycle();

    // 4: redirect, ack and pop in the same cycle with two entries queued
    do_reset();
    auto_ack = 1'b1;
    repeat (3) cycle();
    chk("t4_count2", {29'h0, q_count}, 32'd2);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("t4_count0", {29'h0, q_count}, 32'd0);
    chk("t4_valid0", {31'h0, instr_valid}, 32'h0);
    chk("t4_addr", imem_addr, 32'h40);
    instr_ready = 1'b1;
    repeat (5) cycle();

    // 5: asynchronous reset between clock edges
    do_reset();
    auto_ack = 1'b1;
    repeat (3) cycle();
    chk("t5_pre_req", {31'h0, imem_req}, 32'h1);
    chk("t5_pre_count", {29'h0, q_count}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_req", {31'h0, imem_req}, 32'h0);
    chk("t5_async_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5_async_count", {29'h0, q_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    exp_pc = RESET_PC;
    instr_ready = 1'b1;
    cycle();
    chk("t5_req_after", {31'h0, imem_req}, 32'h1);
    chk("t5_addr_after", imem_addr, RESET_PC);
    repeat (4) cycle();

    // 6: unaligned redirect and address wrap at 2^32
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    cycle();
    redirect = 1'b0;
    chk("t6_align", imem_addr, 32'h100);
    repeat (4) cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    cycle();
    redirect = 1'b0;
    chk("t6_top", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("t6_wrap", imem_addr, 32'h0);
    repeat (5) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
